// File: rtl/i2c_slave_regfile.sv
// I2C slave (7-bit address) exposing a byte register file with a persistent
// auto-incrementing pointer, plus a local host write port.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16,
  parameter int         AW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  sda_oe,
  input  logic                  host_we,
  input  logic [AW-1:0]         host_addr,
  input  logic [7:0]            host_wdata,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_stb,
  output logic [AW-1:0]         wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_PTR      = 4'd3;
  localparam logic [3:0] S_PTR_ACK  = 4'd4;
  localparam logic [3:0] S_WDATA    = 4'd5;
  localparam logic [3:0] S_WACK     = 4'd6;
  localparam logic [3:0] S_RDATA    = 4'd7;
  localparam logic [3:0] S_RACK     = 4'd8;
  localparam logic [3:0] S_WAIT     = 4'd9;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_h_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_h_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_i; scl_s2_q <= scl_s1_q; scl_h_q <= scl_s2_q;
      sda_s1_q <= sda_i; sda_s2_q <= sda_s1_q; sda_h_q <= sda_s2_q;
    end
  end

  logic scl_rise, scl_fall, bus_start, bus_stop;
  assign scl_rise  =  scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q &  scl_h_q;
  assign bus_start =  scl_s2_q &  scl_h_q &  sda_h_q & ~sda_s2_q;
  assign bus_stop  =  scl_s2_q &  scl_h_q & ~sda_h_q &  sda_s2_q;

  logic [3:0]    state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          oe_q, oe_d;
  logic          busy_q, stb_q;
  logic [AW-1:0] waddr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    regs_q [NUM_REGS];
  logic          i2c_we;
  logic [7:0]    rx_byte;

  assign rx_byte = {shift_q[6:0], sda_s2_q};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    oe_d     = oe_q;
    i2c_we   = 1'b0;
    if (bus_start) begin
      state_d  = S_ADDR;
      bitcnt_d = '0;
      oe_d     = 1'b0;
    end else if (bus_stop) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_WAIT: ;
        // Receive states share the shifter; the byte is acted on at the fall after bit 8.
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise && bitcnt_q < 4'd8) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (state_q == S_WDATA && bitcnt_q == 4'd7) begin
              i2c_we = 1'b1;
              ptr_d  = ptr_q + AW'(1);
            end
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            if (state_q == S_ADDR && shift_q[7:1] != SLAVE_ADDR) begin
              state_d = S_WAIT;
            end else begin
              oe_d = 1'b1;
              case (state_q)
                S_ADDR: begin state_d = S_ADDR_ACK; rw_d = shift_q[0]; end
                S_PTR:  begin state_d = S_PTR_ACK;  ptr_d = shift_q[AW-1:0]; end
                default: state_d = S_WACK;
              endcase
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_d = '0;
            if (rw_q) begin
              state_d = S_RDATA;
              shift_d = regs_q[ptr_q];
              oe_d    = ~regs_q[ptr_q][7];
            end else begin
              state_d = S_PTR;
              oe_d    = 1'b0;
            end
          end
        end
        S_PTR_ACK, S_WACK: begin
          if (scl_fall) begin
            state_d  = S_WDATA;
            bitcnt_d = '0;
            oe_d     = 1'b0;
          end
        end
        S_RDATA: begin
          if (scl_rise && bitcnt_q < 4'd8) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            state_d = S_RACK;
            oe_d    = 1'b0;
          end else if (scl_fall && bitcnt_q != 4'd0) begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
          end
        end
        // Entered on a fall, so the next fall always follows an ACKed rise.
        S_RACK: begin
          if (scl_rise) begin
            if (sda_s2_q) state_d = S_WAIT;
            else          ptr_d   = ptr_q + AW'(1);
          end else if (scl_fall) begin
            state_d  = S_RDATA;
            bitcnt_d = '0;
            shift_d  = regs_q[ptr_q];
            oe_d     = ~regs_q[ptr_q][7];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      stb_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      oe_q     <= oe_d;
      busy_q   <= (state_d != S_IDLE) && (state_d != S_ADDR) && (state_d != S_WAIT);
      stb_q    <= i2c_we;
      if (i2c_we) begin
        waddr_q <= ptr_q;
        wdata_q <= rx_byte;
      end
      // Later assignment wins, so an I2C write beats a same-cycle host write.
      if (host_we) regs_q[host_addr] <= host_wdata;
      if (i2c_we)  regs_q[ptr_q]     <= rx_byte;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs_q[i];
  end

  assign sda_o   = 1'b0;
  assign sda_oe  = oe_q;
  assign wr_stb  = stb_q;
  assign wr_addr = waddr_q;
  assign wr_data = wdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench: bit-banged I2C master against a transaction-level register/pointer model.
module tb_i2c_slave_regfile;
  localparam int NR  = 16;
  localparam int AWB = $clog2(NR);
  localparam int Q   = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic host_we = 1'b0;
  logic [AWB-1:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic sda_o, sda_oe, wr_stb, busy;
  logic [AWB-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [8*NR-1:0] regs_flat;
  logic sda_line;

  assign sda_line = sda_m & (sda_oe ? sda_o : 1'b1);
  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_o(sda_o), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .regs_flat(regs_flat), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  int n_cmp = 0, n_err = 0;
  logic [7:0] mregs [NR];
  int mptr;
  int exp_stb[$], got_stb[$];
  logic [7:0] txq[$];
  bit coll_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!rst && wr_stb) got_stb.push_back(int'(wr_addr) * 256 + int'(wr_data));

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b0; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b1; qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; qwait(); scl_m = 1'b1; qwait(); qwait(); scl_m = 1'b0; qwait();
    end
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); ack = sda_line; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic read_bit(output logic b);
    qwait(); scl_m = 1'b1; qwait(); b = sda_line; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) read_bit(b[i]);
    sda_m = nack; qwait(); scl_m = 1'b1; qwait(); qwait(); scl_m = 1'b0; qwait(); sda_m = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    mptr = 0;
    exp_stb.delete();
    got_stb.delete();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) check(tag, 32'(regs_flat[8*i +: 8]), 32'(mregs[i]));
  endtask

  task automatic check_stb();
    int n;
    check("stb_count", got_stb.size(), exp_stb.size());
    n = (got_stb.size() < exp_stb.size()) ? got_stb.size() : exp_stb.size();
    for (int i = 0; i < n; i++) check("stb_entry", got_stb[i], exp_stb[i]);
    got_stb.delete();
    exp_stb.delete();
  endtask

  task automatic host_wr(input int a, input logic [7:0] d);
    host_addr = AWB'(a); host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    mregs[a] = d;
    check("host_wr", 32'(regs_flat[8*a +: 8]), 32'(d));
  endtask

  // Address byte then txq; first data byte is the pointer, the rest are stored.
  task automatic wr_txn(input logic [7:0] ab, input bit do_stop);
    logic ack;
    bit match;
    match = (ab[7:1] == 7'h50);
    i2c_start();
    write_byte(ab, ack);
    check("addr_ack", 32'(ack), 32'(!match));
    check("busy_addr", 32'(busy), 32'(match));
    foreach (txq[i]) begin
      write_byte(txq[i], ack);
      check("data_ack", 32'(ack), 32'(!match));
      if (match) begin
        if (i == 0) mptr = txq[i] % NR;
        else begin
          mregs[mptr] = txq[i];
          exp_stb.push_back(mptr * 256 + int'(txq[i]));
          mptr = (mptr + 1) % NR;
        end
      end
    end
    if (do_stop) begin
      i2c_stop();
      check("busy_stop", 32'(busy), 32'd0);
    end
    check_regs("reg_after_wr");
    check_stb();
  endtask

  task automatic rd_txn(input int n);
    logic ack;
    logic [7:0] b;
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    check("busy_rd", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, i == n - 1);
      check("rd_data", 32'(b), 32'(mregs[mptr]));
      if (i != n - 1) mptr = (mptr + 1) % NR;
    end
    check("busy_wait", 32'(busy), 32'd0);
    i2c_stop();
  endtask

  initial begin
    logic ack;
    logic b;
    int mode, k;
    logic [6:0] a7;

    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_oe", 32'(sda_oe), 32'd0);
    check("rst_sda_o", 32'(sda_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stb", 32'(wr_stb), 32'd0);
    check("rst_waddr", 32'(wr_addr), 32'd0);
    check("rst_wdata", 32'(wr_data), 32'd0);
    check_regs("rst_reg");
    repeat (8) @(negedge clk);

    host_wr(5, 8'h5E);
    txq = '{8'h03, 8'h11, 8'h22};
    wr_txn(8'hA0, 1'b1);
    rd_txn(1);

    txq = '{8'h0F, 8'hAA, 8'hBB};
    wr_txn(8'hA0, 1'b1);

    txq = '{8'h03};
    wr_txn(8'hA0, 1'b0);
    rd_txn(2);

    txq = '{8'h99};
    wr_txn(8'hA2, 1'b1);

    i2c_start();
    write_byte(8'hA0, ack); check("coll_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h05, ack); check("coll_ptr_ack", 32'(ack), 32'd0);
    coll_seen = 1'b0;
    fork
      write_byte(8'h55, ack);
      begin
        host_addr = AWB'(5); host_wdata = 8'h77; host_we = 1'b1;
        k = 0;
        while (k < 400 && !coll_seen) begin
          @(negedge clk);
          if (wr_stb) coll_seen = 1'b1;
          k++;
        end
        host_we = 1'b0;
      end
    join
    check("coll_data_ack", 32'(ack), 32'd0);
    check("coll_stb_seen", 32'(coll_seen), 32'd1);
    mregs[5] = 8'h55;
    exp_stb.push_back(5 * 256 + 8'h55);
    mptr = 6;
    i2c_stop();
    check_regs("coll_reg");
    check_stb();

    host_wr(6, 8'hE5);
    txq = '{8'h06};
    wr_txn(8'hA0, 1'b0);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rr_addr_ack", 32'(ack), 32'd0);
    sda_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      read_bit(b);
      check("rr_bit", 32'(b), 32'd1);
    end
    qwait(); scl_m = 1'b1; qwait();
    check("rr_oe_before", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rr_oe_after", 32'(sda_oe), 32'd0);
    check("rr_busy_after", 32'(busy), 32'd0);
    rst = 1'b0;
    model_reset();
    qwait(); scl_m = 1'b0; qwait();
    i2c_stop();
    check_regs("rr_reg");
    txq = '{8'h02, 8'h5A, 8'hC3};
    wr_txn(8'hA0, 1'b1);
    rd_txn(1);

    for (int it = 0; it < 25; it++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin
          txq.delete();
          txq.push_back(8'($urandom_range(0, 255)));
          for (int j = 0; j < $urandom_range(1, 3); j++) txq.push_back(8'($urandom_range(0, 255)));
          wr_txn(8'hA0, 1'b1);
        end
        1: rd_txn($urandom_range(1, 3));
        2: begin
          host_wr($urandom_range(0, NR - 1), 8'($urandom_range(0, 255)));
          check_regs("rnd_host_reg");
        end
        3: begin
          a7 = 7'($urandom_range(0, 127));
          if (a7 == 7'h50) a7 = 7'h51;
          txq = '{8'($urandom_range(0, 255))};
          wr_txn({a7, 1'($urandom_range(0, 1))}, 1'b1);
        end
        default: begin
          txq = '{8'($urandom_range(0, 255))};
          wr_txn(8'hA0, 1'b0);
          rd_txn($urandom_range(1, 3));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
